alu_imm_mux: RTL and testbench
==============================

ALU_IMM_MUX -- requirements
Module: alu_imm_mux

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width; the only supported value is 64.
REQ-002 SHALL have port clk, input, 1 bit, sole clock; all registers update on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, reset, synchronous and active-high.
REQ-004 SHALL have port instr, input, 32 bits, raw instruction used as the immediate source.
REQ-005 SHALL have port imm_src, input, 2 bits, immediate format select.
REQ-006 SHALL have port rs1_data, input, XLEN bits, ALU operand A.
REQ-007 SHALL have port rs2_data, input, XLEN bits, register operand for B.
REQ-008 SHALL have port alu_src, input, 1 bit, B-operand mux select: 0 = rs2_data, 1 = imm_out.
REQ-009 SHALL have port alu_sel, input, 3 bits, ALU operation select.
REQ-010 SHALL have port sub, input, 1 bit, operation modifier: subtract for ADD, arithmetic shift for SRL.
REQ-011 SHALL have port imm_out, output, XLEN bits, combinational sign-extended immediate.
REQ-012 SHALL have port alu_out, output, XLEN bits, combinational ALU result.
REQ-013 SHALL have port carry_out, output, 1 bit, combinational adder carry.
REQ-014 SHALL have port zero, output, 1 bit, combinational flag: alu_out == 0.
REQ-015 SHALL have ports alu_out_q (XLEN bits), carry_q (1 bit) and zero_q (1 bit), all outputs, holding the registered copies of alu_out, carry_out and zero.

Function
REQ-016 SHALL generate imm_out from imm_src as follows, each value sign-extended from instr[31] to XLEN:
- 00 = I-type, instr[31:20].
- 01 = S-type, {instr[31:25], instr[11:7]}.
- 10 = B-type, {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- 11 = J-type, {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
REQ-017 SHALL form operand B as rs2_data when alu_src=0 and imm_out when alu_src=1, with no other encodings.
REQ-018 SHALL implement alu_sel 000 as A+B when sub=0 and A-B (computed as A+~B+1) when sub=1.
REQ-019 SHALL implement alu_sel 001 as A << B[5:0].
REQ-020 SHALL implement alu_sel 010 as signed A<B, giving 1 when true, else 0.
REQ-021 SHALL implement alu_sel 011 as unsigned A<B, giving 1 when true, else 0.
REQ-022 SHALL implement alu_sel 100 as A ^ B.
REQ-023 SHALL implement alu_sel 101 as A >> B[5:0], logical when sub=0 and arithmetic when sub=1.
REQ-024 SHALL implement alu_sel 110 as A | B.
REQ-025 SHALL implement alu_sel 111 as A & B.
REQ-026 SHALL drive carry_out with bit XLEN of the add/subtract for alu_sel=000; for subtract, 1 means no borrow (A >= B unsigned). For all other alu_sel values carry_out SHALL be 0.
REQ-027 SHALL ignore sub for alu_sel values other than 000 and 101.
REQ-028 SHALL wrap ADD and SUB results modulo 2^XLEN, with no overflow trap.
REQ-029 SHALL settle imm_out, alu_out, carry_out and zero combinationally in the same cycle as their inputs, with zero latency.
REQ-030 SHALL, at every clk rising edge with rst=0, load alu_out_q, carry_q and zero_q from alu_out, carry_out and zero, giving a latency of 1 cycle.

Reset
REQ-031 SHALL, when rst=1 at a rising edge, set alu_out_q=0, carry_q=0 and zero_q=0, overriding the load.
REQ-032 SHALL keep the combinational outputs functional during reset.
REQ-033 SHALL allow reset to be asserted mid-stream; it clears the registered outputs on the next edge, and normal loading resumes on the first edge with rst=0.

Structure
REQ-034 SHALL place the ALU operation encodings (ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND) and the immediate format encodings (IMM_I, IMM_S, IMM_B, IMM_J) in a shared package.
REQ-035 SHALL use one sub-module, imm_gen, for immediate generation, instantiated once; the mux and ALU are inline.

Verification
REQ-036 SHALL cover: instr=0xFFF00093, imm_src=00, alu_src=1, rs1_data=1, alu_sel=000, sub=0 -> imm_out=0xFFFFFFFFFFFFFFFF, alu_out=0, zero=1, carry_out=1.
REQ-037 SHALL cover: instr=0x0020B423, imm_src=01 -> imm_out=8; instr=0xFE000EE3, imm_src=10 -> imm_out=0xFFFFFFFFFFFFFFFC.
REQ-038 SHALL cover: rs1_data=3, rs2_data=5, alu_src=0, alu_sel=000, sub=1 -> alu_out=0xFFFFFFFFFFFFFFFE, carry_out=0, zero=0; then alu_sel=010 -> alu_out=1.
REQ-039 SHALL cover: rs1_data=0x8000000000000000, rs2_data=4, alu_sel=101: sub=1 -> 0xF800000000000000; sub=0 -> 0x0800000000000000.
REQ-040 SHALL cover: rs1_data=0xFFFFFFFFFFFFFFFF, rs2_data=1, alu_sel=011 -> alu_out=0, zero=1; one edge later zero_q=1.
REQ-041 SHALL cover: rst=1 for one edge while alu_out is nonzero -> alu_out_q=0, carry_q=0 and zero_q=0; at the next edge with rst=0 the registered outputs reload.

Source files
------------

// File: rtl/alu_imm_mux_pkg.sv
// Shared encodings for the immediate generator and the ALU operation select.
package alu_imm_mux_pkg;

  typedef enum logic [2:0] {
    ADD  = 3'b000,
    SLL  = 3'b001,
    SLT  = 3'b010,
    SLTU = 3'b011,
    XOR  = 3'b100,
    SRL  = 3'b101,
    OR   = 3'b110,
    AND  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_fmt_e;

endpackage

// File: rtl/alu_imm_mux_imm_gen.sv
// Sign-extended immediate decode for I/S/B/J instruction formats.
module imm_gen
  import alu_imm_mux_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  input  logic [1:0]      imm_src,
  output logic [XLEN-1:0] imm
);

  logic sgn;
  assign sgn = instr[31];

  // Opcode bits never contribute to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm = '0;
    case (imm_fmt_e'(imm_src))
      IMM_I: imm = {{(XLEN-12){sgn}}, instr[31:20]};
      IMM_S: imm = {{(XLEN-12){sgn}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{(XLEN-13){sgn}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J: imm = {{(XLEN-21){sgn}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/alu_imm_mux.sv
// Immediate generator, B-operand mux and ALU, with a one-cycle registered copy of the result.
module alu_imm_mux
  import alu_imm_mux_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic [1:0]      imm_src,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            alu_src,
  input  logic [2:0]      alu_sel,
  input  logic            sub,
  output logic [XLEN-1:0] imm_out,
  output logic [XLEN-1:0] alu_out,
  output logic            carry_out,
  output logic            zero,
  output logic [XLEN-1:0] alu_out_q,
  output logic            carry_q,
  output logic            zero_q
);

  logic [XLEN-1:0] a, b;
  logic [XLEN:0]   sum;
  logic [5:0]      shamt;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr   (instr),
    .imm_src (imm_src),
    .imm     (imm_out)
  );

  assign a     = rs1_data;
  assign b     = alu_src ? imm_out : rs2_data;
  assign shamt = b[5:0];

  // Subtract as A + ~B + 1 so bit XLEN reads as "no borrow".
  assign sum = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{XLEN{1'b0}}, sub};

  always_comb begin
    alu_out   = '0;
    carry_out = 1'b0;
    case (alu_op_e'(alu_sel))
      ADD: begin
        alu_out   = sum[XLEN-1:0];
        carry_out = sum[XLEN];
      end
      SLL:  alu_out = a << shamt;
      SLT:  alu_out = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      SLTU: alu_out = {{(XLEN-1){1'b0}}, (a < b)};
      XOR:  alu_out = a ^ b;
      SRL:  alu_out = sub ? XLEN'($signed(a) >>> shamt) : (a >> shamt);
      OR:   alu_out = a | b;
      AND:  alu_out = a & b;
      default: alu_out = '0;
    endcase
  end

  assign zero = (alu_out == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out_q <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      alu_out_q <= alu_out;
      carry_q   <= carry_out;
      zero_q    <= zero;
    end
  end

endmodule

// File: tb/tb_alu_imm_mux.sv
// Directed-vector bench for alu_imm_mux with hand-computed expectations.
module tb_alu_imm_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [1:0]  imm_src;
  logic [63:0] rs1_data, rs2_data;
  logic        alu_src;
  logic [2:0]  alu_sel;
  logic        sub;
  logic [63:0] imm_out, alu_out, alu_out_q;
  logic        carry_out, zero, carry_q, zero_q;

  int n_checks = 0;
  int n_fail   = 0;

  alu_imm_mux #(.XLEN(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .imm_src   (imm_src),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .alu_src   (alu_src),
    .alu_sel   (alu_sel),
    .sub       (sub),
    .imm_out   (imm_out),
    .alu_out   (alu_out),
    .carry_out (carry_out),
    .zero      (zero),
    .alu_out_q (alu_out_q),
    .carry_q   (carry_q),
    .zero_q    (zero_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply ALU operands and let combinational outputs settle.
  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic src,
                       input logic [2:0] sel, input logic s);
    rs1_data = a; rs2_data = b; alu_src = src; alu_sel = sel; sub = s;
    #2;
  endtask

  initial begin
    rst = 1'b1; instr = '0; imm_src = 2'b00;
    rs1_data = '0; rs2_data = '0; alu_src = 1'b0; alu_sel = 3'b000; sub = 1'b0;
    tick();
    check("reset_alu_out_q", alu_out_q, 64'h0);
    check("reset_carry_q",   {63'b0, carry_q}, 64'h0);
    check("reset_zero_q",    {63'b0, zero_q},  64'h0);
    check("comb_zero_in_reset", {63'b0, zero}, 64'h1);
    rst = 1'b0;

    // I-type -1 added to 1
    instr = 32'hFFF00093; imm_src = 2'b00;
    drive(64'd1, 64'd0, 1'b1, 3'b000, 1'b0);
    check("imm_i_neg",   imm_out, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_out",    alu_out, 64'h0);
    check("addi_zero",   {63'b0, zero}, 64'h1);
    check("addi_carry",  {63'b0, carry_out}, 64'h1);
    tick();
    check("addi_out_q",  alu_out_q, 64'h0);
    check("addi_carry_q", {63'b0, carry_q}, 64'h1);
    check("addi_zero_q", {63'b0, zero_q}, 64'h1);

    // Immediate formats
    instr = 32'h0020B423; imm_src = 2'b01; #2;
    check("imm_s", imm_out, 64'h8);
    instr = 32'hFE000EE3; imm_src = 2'b10; #2;
    check("imm_b_neg", imm_out, 64'hFFFF_FFFF_FFFF_FFFC);
    instr = 32'h0080006F; imm_src = 2'b11; #2;
    check("imm_j_pos", imm_out, 64'h8);
    instr = 32'h800000EF; imm_src = 2'b11; #2;
    check("imm_j_neg", imm_out, 64'hFFFF_FFFF_FFF0_0000);
    instr = 32'h7FF00000; imm_src = 2'b00; #2;
    check("imm_i_pos", imm_out, 64'h7FF);
    // alu_src=1 feeds 0x7FF as B
    drive(64'h1, 64'h0, 1'b1, 3'b000, 1'b0);
    check("addi_pos", alu_out, 64'h800);

    // Subtract with borrow, then compares
    drive(64'd3, 64'd5, 1'b0, 3'b000, 1'b1);
    check("sub_borrow_out",   alu_out, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_borrow_carry", {63'b0, carry_out}, 64'h0);
    check("sub_borrow_zero",  {63'b0, zero}, 64'h0);
    drive(64'd3, 64'd5, 1'b0, 3'b010, 1'b1);
    check("slt_3_5", alu_out, 64'h1);
    check("slt_carry_zero", {63'b0, carry_out}, 64'h0);
    drive(64'd3, 64'd5, 1'b0, 3'b011, 1'b0);
    check("sltu_3_5", alu_out, 64'h1);
    drive(64'd5, 64'd3, 1'b0, 3'b000, 1'b1);
    check("sub_noborrow_out",   alu_out, 64'h2);
    check("sub_noborrow_carry", {63'b0, carry_out}, 64'h1);

    // Shifts
    drive(64'h8000_0000_0000_0000, 64'd4, 1'b0, 3'b101, 1'b1);
    check("sra", alu_out, 64'hF800_0000_0000_0000);
    drive(64'h8000_0000_0000_0000, 64'd4, 1'b0, 3'b101, 1'b0);
    check("srl", alu_out, 64'h0800_0000_0000_0000);
    drive(64'd1, 64'h43, 1'b0, 3'b001, 1'b0);
    check("sll_shamt6", alu_out, 64'h8);

    // Logic ops; sub must be ignored outside ADD/SRL
    drive(64'hF0F0, 64'hFF00, 1'b0, 3'b100, 1'b1);
    check("xor_sub_ignored", alu_out, 64'h0FF0);
    drive(64'hF0F0, 64'hFF00, 1'b0, 3'b110, 1'b0);
    check("or",  alu_out, 64'hFFF0);
    drive(64'hF0F0, 64'hFF00, 1'b0, 3'b111, 1'b1);
    check("and", alu_out, 64'hF000);

    // Signed vs unsigned compare of -1 and 1
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 3'b010, 1'b0);
    check("slt_neg1_1", alu_out, 64'h1);
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 3'b011, 1'b0);
    check("sltu_max_1", alu_out, 64'h0);
    check("sltu_zero",  {63'b0, zero}, 64'h1);
    tick();
    check("sltu_zero_q", {63'b0, zero_q}, 64'h1);
    check("sltu_out_q",  alu_out_q, 64'h0);

    // Wrap-around add producing carry, then reset mid-stream
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 3'b000, 1'b0);
    check("add_wrap",       alu_out, 64'h1);
    check("add_wrap_carry", {63'b0, carry_out}, 64'h1);
    tick();
    check("add_wrap_q",       alu_out_q, 64'h1);
    check("add_wrap_carry_q", {63'b0, carry_q}, 64'h1);
    rst = 1'b1;
    tick();
    check("midrst_out_q",   alu_out_q, 64'h0);
    check("midrst_carry_q", {63'b0, carry_q}, 64'h0);
    check("midrst_zero_q",  {63'b0, zero_q}, 64'h0);
    check("midrst_comb_live", alu_out, 64'h1);
    rst = 1'b0;
    tick();
    check("reload_out_q",   alu_out_q, 64'h1);
    check("reload_carry_q", {63'b0, carry_q}, 64'h1);
    check("reload_zero_q",  {63'b0, zero_q}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
